// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock-enable generator: each channel emits a one-cycle
// tick and a 50%-duty div_clk, free-running from a divisor or single-stepped by a button.
module clk_div_multi #(
  parameter int                       N_CH     = 2,
  parameter int                       CNT_W    = 16,
  parameter logic [N_CH*CNT_W-1:0]    DIV_INIT = {16'd4, 16'd2}
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [N_CH-1:0]         mode,
  input  logic                    step,
  input  logic [N_CH-1:0]         div_load,
  input  logic [N_CH*CNT_W-1:0]   div_val,
  output logic [N_CH-1:0]         tick,
  output logic [N_CH-1:0]         div_clk
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic r_step_q;
  logic w_step_rise;

  // The step input is shared, so one edge detector serves every channel.
  assign w_step_rise = step & ~r_step_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step_q <= 1'b0;
    end else begin
      r_step_q <= step;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_cnt;
    logic             r_mode_q;
    logic             r_tick;
    logic             r_div_clk;
    logic             w_last;

    // Only evaluated when r_div is non-zero, so the subtraction never wraps.
    assign w_last = (r_cnt == (r_div - ONE));

    // NOTE: reset is asynchronous; a partial count is discarded the moment rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_div     <= DIV_INIT[g*CNT_W +: CNT_W];
        r_cnt     <= '0;
        r_mode_q  <= 1'b0;
        r_tick    <= 1'b0;
        r_div_clk <= 1'b0;
      end else if (div_load[g]) begin
        r_div  <= div_val[g*CNT_W +: CNT_W];
        r_cnt  <= '0;
        r_tick <= 1'b0;
      end else if (mode[g] != r_mode_q) begin
        r_mode_q <= mode[g];
        r_cnt    <= '0;
        r_tick   <= 1'b0;
      end else if (r_mode_q) begin
        r_cnt  <= '0;
        r_tick <= w_step_rise;
        if (w_step_rise) begin
          r_div_clk <= ~r_div_clk;
        end
      end else if (en && (r_div != '0)) begin
        if (w_last) begin
          r_cnt     <= '0;
          r_tick    <= 1'b1;
          r_div_clk <= ~r_div_clk;
        end else begin
          r_cnt  <= r_cnt + ONE;
          r_tick <= 1'b0;
        end
      end else begin
        // Halted (D=0) or frozen (en=0): count and div_clk hold.
        r_tick <= 1'b0;
      end
    end

    assign tick[g]    = r_tick;
    assign div_clk[g] = r_div_clk;
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: per-cycle scoreboard against a behavioural
// model, plus a table of hand-derived tick counts and div_clk levels per phase.
module tb_clk_div_multi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        step = 1'b0;
  logic [1:0]  mode = '0;
  logic [1:0]  div_load = '0;
  logic [31:0] div_val = '0;
  logic [1:0]  tick;
  logic [1:0]  div_clk;

  clk_div_multi #(.N_CH(2), .CNT_W(16), .DIV_INIT({16'd4, 16'd2})) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .mode     (mode),
    .step     (step),
    .div_load (div_load),
    .div_val  (div_val),
    .tick     (tick),
    .div_clk  (div_clk)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [1:0]  mode;
    logic        step;
    logic [1:0]  load;
    logic [15:0] v0;
    logic [15:0] v1;
    int          ncyc;
    int          t0;
    int          t1;
    logic        dc0;
    logic        dc1;
  } vec_t;

  vec_t tbl[23];

  int n_vec  = 0;
  int n_miss = 0;

  logic [3:0] sb_q[$];

  logic [15:0] m_div[2];
  logic [15:0] m_cnt[2];
  logic        m_mq[2];
  logic        m_tick[2];
  logic        m_dclk[2];
  logic        m_sq;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_div[0] = 16'd2;
    m_div[1] = 16'd4;
    for (int c = 0; c < 2; c++) begin
      m_cnt[c]  = '0;
      m_mq[c]   = 1'b0;
      m_tick[c] = 1'b0;
      m_dclk[c] = 1'b0;
    end
    m_sq = 1'b0;
  endtask

  // Next-state of the reference model from the inputs currently driven.
  task automatic model_step();
    for (int c = 0; c < 2; c++) begin
      if (div_load[c]) begin
        m_div[c]  = div_val[c*16 +: 16];
        m_cnt[c]  = '0;
        m_tick[c] = 1'b0;
      end else if (mode[c] != m_mq[c]) begin
        m_mq[c]   = mode[c];
        m_cnt[c]  = '0;
        m_tick[c] = 1'b0;
      end else if (m_mq[c]) begin
        m_tick[c] = step && !m_sq;
        if (m_tick[c]) m_dclk[c] = ~m_dclk[c];
        m_cnt[c] = '0;
      end else if (en && m_div[c] != 16'd0) begin
        if (m_cnt[c] == m_div[c] - 16'd1) begin
          m_cnt[c]  = '0;
          m_tick[c] = 1'b1;
          m_dclk[c] = ~m_dclk[c];
        end else begin
          m_cnt[c]  = m_cnt[c] + 16'd1;
          m_tick[c] = 1'b0;
        end
      end else begin
        m_tick[c] = 1'b0;
      end
    end
    m_sq = step;
  endtask

  task automatic cycle();
    logic [3:0] e;
    model_step();
    sb_q.push_back({m_dclk[1], m_dclk[0], m_tick[1], m_tick[0]});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("cycle {div_clk,tick}", 32'({div_clk, tick}), 32'(e));
  endtask

  task automatic apply_row(input int idx);
    vec_t v;
    int   c0;
    int   c1;
    v  = tbl[idx];
    c0 = 0;
    c1 = 0;
    en       = v.en;
    mode     = v.mode;
    step     = v.step;
    div_load = v.load;
    div_val  = {v.v1, v.v0};
    for (int i = 0; i < v.ncyc; i++) begin
      cycle();
      div_load = '0;
      c0 += int'(tick[0]);
      c1 += int'(tick[1]);
    end
    check($sformatf("row%0d ticks ch0", idx), 32'(c0), 32'(v.t0));
    check($sformatf("row%0d ticks ch1", idx), 32'(c1), 32'(v.t1));
    check($sformatf("row%0d div_clk", idx), 32'(div_clk), 32'({v.dc1, v.dc0}));
  endtask

  initial begin
    int  n;
    bit  found;
    int  first0;
    int  first1;

    //                en    mode   step  load   v0        v1      n   t0 t1 dc0   dc1
    tbl[0]  = '{1'b1, 2'b00, 1'b0, 2'b11, 16'd4,    16'd10, 1,  0, 0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 2'b00, 1'b0, 2'b00, 16'd0,    16'd0,  12, 3, 1, 1'b1, 1'b1};
    tbl[2]  = '{1'b0, 2'b00, 1'b0, 2'b00, 16'd0,    16'd0,  3,  0, 0, 1'b1, 1'b1};
    tbl[3]  = '{1'b1, 2'b00, 1'b0, 2'b00, 16'd0,    16'd0,  5,  1, 0, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 2'b00, 1'b0, 2'b10, 16'd0,    16'd3,  1,  0, 0, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 2'b00, 1'b0, 2'b00, 16'd0,    16'd0,  9,  2, 3, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 2'b00, 1'b0, 2'b01, 16'd1,    16'd0,  1,  0, 0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 2'b00, 1'b0, 2'b00, 16'd0,    16'd0,  5,  5, 2, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 2'b00, 1'b0, 2'b01, 16'd0,    16'd0,  1,  0, 0, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 2'b00, 1'b0, 2'b00, 16'd0,    16'd0,  20, 0, 7, 1'b1, 1'b1};
    tbl[10] = '{1'b1, 2'b01, 1'b0, 2'b00, 16'd0,    16'd0,  1,  0, 0, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 2'b01, 1'b1, 2'b00, 16'd0,    16'd0,  5,  1, 0, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 2'b01, 1'b0, 2'b00, 16'd0,    16'd0,  3,  0, 0, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 2'b01, 1'b1, 2'b00, 16'd0,    16'd0,  5,  1, 0, 1'b1, 1'b1};
    tbl[14] = '{1'b0, 2'b01, 1'b0, 2'b00, 16'd0,    16'd0,  1,  0, 0, 1'b1, 1'b1};
    tbl[15] = '{1'b0, 2'b01, 1'b1, 2'b01, 16'd4,    16'd0,  1,  0, 0, 1'b1, 1'b1};
    tbl[16] = '{1'b0, 2'b01, 1'b1, 2'b00, 16'd0,    16'd0,  2,  0, 0, 1'b1, 1'b1};
    tbl[17] = '{1'b0, 2'b01, 1'b0, 2'b00, 16'd0,    16'd0,  1,  0, 0, 1'b1, 1'b1};
    tbl[18] = '{1'b1, 2'b00, 1'b0, 2'b00, 16'd0,    16'd0,  2,  0, 1, 1'b1, 1'b0};
    tbl[19] = '{1'b1, 2'b00, 1'b0, 2'b00, 16'd0,    16'd0,  5,  1, 1, 1'b0, 1'b1};
    tbl[20] = '{1'b1, 2'b01, 1'b0, 2'b00, 16'd0,    16'd0,  8,  0, 3, 1'b0, 1'b0};
    tbl[21] = '{1'b1, 2'b00, 1'b0, 2'b00, 16'd0,    16'd0,  4,  0, 1, 1'b0, 1'b1};
    tbl[22] = '{1'b1, 2'b00, 1'b0, 2'b00, 16'd0,    16'd0,  1,  1, 1, 1'b1, 1'b0};

    model_reset();
    #12;
    check("reset tick", 32'(tick), 32'd0);
    check("reset div_clk", 32'(div_clk), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int r = 0; r < 23; r++) begin
      apply_row(r);
    end

    // Largest divisor: first tick exactly 65535 edges after the load.
    en       = 1'b1;
    mode     = 2'b00;
    step     = 1'b0;
    div_load = 2'b01;
    div_val  = {16'd0, 16'hFFFF};
    cycle();
    div_load = '0;
    n     = 0;
    found = 1'b0;
    for (int i = 0; i < 70000 && !found; i++) begin
      cycle();
      n++;
      if (tick[0]) found = 1'b1;
    end
    check("D=FFFF tick seen", 32'(found), 32'd1);
    check("D=FFFF first tick edge", 32'(n), 32'd65535);

    // Asynchronous reset while ch0 tick is high: outputs clear with no clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset tick", 32'(tick), 32'd0);
    check("async reset div_clk", 32'(div_clk), 32'd0);
    model_reset();
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    mode  = 2'b00;
    step  = 1'b0;

    // Divisors return to DIV_INIT: ch0 D=2, ch1 D=4.
    first0 = 0;
    first1 = 0;
    for (int i = 1; i <= 8; i++) begin
      cycle();
      if (tick[0] && first0 == 0) first0 = i;
      if (tick[1] && first1 == 0) first1 = i;
    end
    check("post-reset first tick ch0", 32'(first0), 32'd2);
    check("post-reset first tick ch1", 32'(first1), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
